// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver (1 start, 8 data LSB-first, 1 stop, idle high).
//
// The serial line passes through a two-flop synchroniser. The start bit is
// confirmed at its centre. Each data bit and the stop bit are then sampled one
// bit period apart. A good frame updates data with a one-cycle done pulse. A
// frame whose stop bit reads 0 gives a one-cycle frame_err pulse instead.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idle = 1
//   data       last correctly framed byte
//   done       one-cycle pulse, data just updated
//   frame_err  one-cycle pulse, stop bit sampled 0
//   busy       high whenever the FSM is not in IDLE
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       done,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic          s1, rx_s;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_cnt, bit_nxt;
   logic [7:0]    sh, sh_nxt;
   logic [7:0]    data_nxt;
   logic          done_nxt, ferr_nxt;
   // Cleared by a frame error. This keeps a held-low line (break) from being
   // taken as a string of new start bits. It is set again once the line is seen high.
   logic          armed, armed_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b1;
         rx_s      <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         sh        <= '0;
         data      <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         armed     <= 1'b1;
      end else begin
         s1        <= rx;
         rx_s      <= s1;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_cnt   <= bit_nxt;
         sh        <= sh_nxt;
         data      <= data_nxt;
         done      <= done_nxt;
         frame_err <= ferr_nxt;
         armed     <= armed_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_cnt;
      sh_nxt    = sh;
      data_nxt  = data;
      done_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
      armed_nxt = armed;
      case (state)
         IDLE: begin
            if (!armed) begin
               if (rx_s) armed_nxt = 1'b1;
            end else if (!rx_s) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         // The edge that saw the falling rx_s is T0. cnt reaches H-1 on the
         // edge T0+H, which is the centre of the start bit.
         START: begin
            if (cnt == HALF_M1) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt = DATA;
                  bit_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_nxt = '0;
               sh_nxt  = {rx_s, sh[7:1]};  // LSB arrives first
               bit_nxt = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               if (rx_s) begin
                  data_nxt = sh;
                  done_nxt = 1'b1;
               end else begin
                  ferr_nxt  = 1'b1;
                  armed_nxt = 1'b0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - directed and random frames for uart_rx.
// The reference model predicts every done/frame_err pulse from the frame
// timing rule: the pulse is observed in the cycle after edge N+2+H+9*C, where
// rx fell just before edge N. It also predicts the byte expected on data.
module tb_uart_rx;
   localparam int C = 16;
   localparam int H = C / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       done, frame_err, busy;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data),
      .done(done), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] cyc;
      logic        d;
      logic        e;
      logic [7:0]  data;
   } ev_t;

   ev_t        obs_q[$];
   ev_t        exp_q[$];
   int         cyc = 0;
   int         vectors = 0;
   int         errs = 0;
   logic [7:0] last_data = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every pulse, including simultaneous or stretched ones.
   always @(negedge clk) begin
      if (done || frame_err) begin
         obs_q.push_back('{cyc: cyc, d: done, e: frame_err, data: data});
      end
   end

   // Call at a negedge, just before rx falls.
   task automatic push_exp(input logic [7:0] b, input logic stop);
      ev_t e;
      e.cyc  = cyc + 1 + 2 + H + 9 * C;
      e.d    = stop;
      e.e    = !stop;
      e.data = stop ? b : last_data;
      exp_q.push_back(e);
      if (stop) last_data = b;
   endtask

   // Called at a negedge. Returns after the stop bit with rx still at the stop value.
   task automatic send(input logic [7:0] b, input logic stop, input bit expect_it);
      if (expect_it) push_exp(b, stop);
      rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (C) @(negedge clk);
      end
      rx = stop;
      repeat (C) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_events(input string tag);
      int n;
      vectors++;
      assert (obs_q.size() === exp_q.size()) else begin
         errs++;
         $error("FAIL %s pulse count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         vectors++;
         assert (obs_q[i] === exp_q[i]) else begin
            errs++;
            $error("FAIL %s pulse %0d: got cyc=%0d done=%b ferr=%b data=%h expected cyc=%0d done=%b ferr=%b data=%h",
                   tag, i, obs_q[i].cyc, obs_q[i].d, obs_q[i].e, obs_q[i].data,
                   exp_q[i].cyc, exp_q[i].d, exp_q[i].e, exp_q[i].data);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_quiet(input string tag);
      vectors++;
      assert ({data, done, frame_err, busy} === {last_data, 3'b000}) else begin
         errs++;
         $error("FAIL %s: got data=%h done=%b ferr=%b busy=%b expected data=%h 0 0 0",
                tag, data, done, frame_err, busy, last_data);
      end
   endtask

   initial begin
      logic       busy_seen;
      logic [7:0] b;
      logic       st;
      int         gap;

      // Reset, then a long idle line.
      repeat (3) begin
         @(negedge clk);
         check_quiet("reset");
      end
      rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         check_quiet("idle");
      end
      check_events("idle");

      // Single frame 0x5D.
      send(8'h5D, 1'b1, 1'b1);
      idle(30);
      check_events("single");

      // Back-to-back frames with no idle gap.
      send(8'h00, 1'b1, 1'b1);
      send(8'hFF, 1'b1, 1'b1);
      send(8'hA5, 1'b1, 1'b1);
      idle(30);
      check_events("b2b");

      // A 3-cycle glitch: busy rises briefly, and no pulse follows.
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < 40; i++) begin
         busy_seen |= busy;
         @(negedge clk);
      end
      vectors++;
      assert ({busy_seen, busy} === 2'b10) else begin
         errs++;
         $error("FAIL glitch busy: got seen=%b now=%b expected 1 0", busy_seen, busy);
      end
      check_events("glitch");

      // Stop bit forced low: frame_err is raised and data keeps its value.
      send(8'h3C, 1'b0, 1'b1);
      idle(30);
      check_events("ferr");
      check_quiet("ferr_hold");

      // Reset in the middle of data bit 4. Reset is held until the frame has ended.
      fork
         send(8'hC3, 1'b1, 1'b0);
         begin
            repeat (5 * C + C / 2) @(negedge clk);
            rst = 1'b1;
            last_data = 8'h00;
            @(negedge clk);
            vectors++;
            assert ({busy, data} === 9'h000) else begin
               errs++;
               $error("FAIL rst_mid: got busy=%b data=%h expected 0 00", busy, data);
            end
         end
      join
      idle(3);
      rst = 1'b0;
      idle(20);
      check_events("rst_mid");
      send(8'h81, 1'b1, 1'b1);
      idle(30);
      check_events("after_rst");

      // Break: the line is held low for 400 cycles, giving exactly one frame_err.
      push_exp(8'h00, 1'b0);
      rx = 1'b0;
      repeat (400) @(negedge clk);
      idle(300);
      check_events("break");
      check_quiet("break_quiet");
      b = 8'($urandom);
      send(b, 1'b1, 1'b1);
      idle(30);
      check_events("after_break");

      // Random frames with random gaps. A bad stop bit is followed by an idle-high gap.
      for (int k = 0; k < 12; k++) begin
         b   = 8'($urandom);
         st  = ($urandom_range(0, 4) != 0);
         gap = st ? $urandom_range(0, 12) : $urandom_range(2, 12);
         send(b, st, 1'b1);
         if (gap > 0) idle(gap);
      end
      idle(40);
      check_events("random");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   // Backstop so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the far end of the team's uart transmitter link (8N1: one start bit, 8 data bits LSB-first, one stop bit, line idles high).
- Synchronises the asynchronous serial line into the clk domain and validates the start bit at mid-bit.
- Samples each data bit and the stop bit at bit centre, then presents the byte with a one-cycle done strobe.
- Sits between the pad/loopback of the transmitter's out and the consuming logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range ≥4. H = CLKS_PER_BIT/2 (integer division).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line; idle = 1.
data  output  8  last correctly framed byte.
done  output  1  one-cycle pulse: data updated with a new byte.
frame_err  output  1  one-cycle pulse: stop bit sampled 0.
busy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, both synchroniser flops=1, bit counter=0, cycle counter=0.
  - Outputs: data=8'h00, done=0, frame_err=0, busy=0.
  - Applies mid-frame too: the partial frame is discarded and no done or frame_err is issued for it.
- Synchroniser: two flops, rx -> s1 -> rx_s. All decisions use rx_s only.
- Timing reference: rx falls before edge N. Then rx_s=0 is first seen by the FSM at edge N+2, called T0.
- FSM states IDLE, START, DATA, STOP:
  - IDLE:
    - At an edge where rx_s=0 -> START, cycle counter cleared.
    - The start-bit edge is always detected from rx_s=0 seen in IDLE.
  - START:
    - Count H cycles. At edge T0+H, sample rx_s.
    - If rx_s=0 -> DATA, cycle counter and bit counter cleared.
    - If rx_s=1 -> IDLE (glitch rejected, no outputs asserted).
  - DATA:
    - Bit k (k=0..7) is sampled at edge T0+H+(k+1)*CLKS_PER_BIT.
    - Each sample is shifted into an internal shift register, LSB first.
    - After k=7 -> STOP.
  - STOP:
    - Stop bit is sampled at edge T0+H+9*CLKS_PER_BIT.
    - If rx_s=1: data <= shift register, done=1 for exactly the following cycle.
    - If rx_s=0: frame_err=1 for exactly the following cycle, data unchanged.
    - In both cases -> IDLE. After a frame error, IDLE does not re-arm until rx_s=1 has been seen, so a break condition causes no repeated frames.
- done and frame_err are never high together. Each is registered and is a single-cycle pulse per frame.
- data holds its value between frames and changes only at the edge where done rises.
- busy is high from the edge entering START through the edge returning to IDLE.
- Back-to-back frames:
  - The FSM returns to IDLE at mid-stop-bit.
  - A start bit beginning immediately after the stop bit (≥H cycles later) is received without loss.
- Total latency: done is high in the cycle after edge N+2+H+9*CLKS_PER_BIT.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, rx=1 for 200 cycles -> data=8'h00, done=0, frame_err=0, busy=0 throughout.
- Single frame, CLKS_PER_BIT=16: send 8'b01011101 (bits 1,0,1,1,1,0,1,0 LSB-first, stop=1) -> exactly one done pulse at edge N+2+8+144, data=8'h5D, frame_err=0.
- Back-to-back: frames 8'h00, 8'hFF, 8'hA5 with no idle gap -> three done pulses spaced 160 cycles apart, data sequence 00, FF, A5.
- Glitch and framing:
  - 3-cycle low pulse on rx -> busy rises then falls, no done, no frame_err.
  - Frame 8'h3C with stop bit forced 0 -> one frame_err pulse, data keeps its previous value, no done.
- Reset mid-frame: assert rst during data bit 4 of frame 8'hC3 -> next cycle busy=0, data=8'h00. That frame yields no done. Next clean frame 8'h81 -> done, data=8'h81.
- Break: hold rx=0 for 400 cycles then release -> exactly one frame_err, no further pulses until the next valid frame.
